contador_hms_param: RTL and testbench
=====================================

# contador_hms_param

Parametrised BCD time-of-day counter: successor to the fixed 50 MHz HH:MM:SS counter. Adds a configurable prescaler divisor, runtime 12/24-hour display mode with PM flag, validated synchronous time load, and registered second/day tick pulses. It sits between the board clock and the 7-segment display/alarm logic of the watch.

## Interface
- CLK_HZ, 50_000_000, input clock cycles per second. Must be ≥ 2. Prescaler width is $clog2(CLK_HZ).
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  prescaler advance enable
- clr  in  1  synchronous clear to 00:00:00
- load  in  1  synchronous time load strobe
- ld_h_d, ld_h_u, ld_m_d, ld_m_u, ld_s_d, ld_s_u  in  4 each  BCD load value, 24 h format
- mode_12h  in  1  0 = 24 h display, 1 = 12 h display
- s_unidade, s_dezena, m_unidade, m_dezena  out  4 each  BCD seconds/minutes
- h_unidade, h_dezena  out  4 each  BCD hours, display-formatted per mode_12h
- pm  out  1  1 when internal hour ≥ 12, regardless of mode
- seg_tick  out  1  one-cycle pulse when seconds advance
- dia_tick  out  1  one-cycle pulse on 23:59:59 → 00:00:00
- load_err  out  1  one-cycle pulse on rejected load

## Operation
- Internal state is 24 h BCD (hd, hu, md, mu, sd, su), plus the prescaler, all registered.
- Priority per clock edge: rst (async) > clr > load > count.
- rst or clr:
  - All digits and the prescaler go to 0.
  - seg_tick, dia_tick and load_err go to 0.
- load, valid (hd ≤ 2; hd = 2 ⇒ hu ≤ 3; hd < 2 ⇒ hu ≤ 9; md ≤ 5; mu ≤ 9; sd ≤ 5; su ≤ 9):
  - Digits take the ld_* values and the prescaler goes to 0.
  - No tick that cycle. load_err = 0.
- load, invalid:
  - State unchanged, prescaler included. Prescaler does not advance that cycle.
  - load_err = 1 for the following cycle.
- Count, when enable = 1:
  - Prescaler ≠ CLK_HZ−1: prescaler +1.
  - Prescaler = CLK_HZ−1: prescaler → 0 and time advances one second.
  - Carries cascade su 9→0, sd 5→0, mu 9→0, md 5→0.
  - Hour increments hu 9→0 with hd +1; hour 23 → 00.
- Count, when enable = 0: prescaler and digits hold; no tick.
- Digits never leave their legal ranges. The hour never takes values 24–29.
- Display hour, combinational from state:
  - mode_12h = 0: hour shown as is.
  - mode_12h = 1: 00 → 12, 01–12 unchanged, 13–23 → 01–11.
  - pm = (hour ≥ 12) in both modes.
  - A mode change affects outputs in the same cycle and never alters state.

## Timing
- Reset values: all digit outputs 0, pm 0, all ticks 0. In 12 h mode after reset the display reads h_dezena = 1, h_unidade = 2.
- Second advance:
  - Happens on the edge where prescaler = CLK_HZ−1 and enable = 1.
  - New digits and seg_tick = 1 are visible in the same following cycle.
  - With enable held high, consecutive seg_ticks are exactly CLK_HZ cycles apart.
- dia_tick is asserted coincident with that seg_tick when the time wraps to 00:00:00.
- Load: takes effect one edge after it is sampled. The next seg_tick follows the load edge by exactly CLK_HZ enabled cycles.
- clr and load in the same cycle: clr wins and load_err = 0.
- rst asserted mid-count: outputs clear immediately, without waiting for a clock edge. Counting resumes on the first edge after deassertion, from prescaler 0.

## Test plan
- CLK_HZ = 4, rst pulse, enable = 1 for 40 cycles:
  - Required: seg_tick on cycles 4, 8, 12, …
  - After 40 cycles: s_dezena = 1, s_unidade = 0.
- Load 23:59:58, enable = 1, run 8 cycles:
  - Required: 23:59:59, then 00:00:00.
  - dia_tick = 1 only with the second seg_tick. pm goes 1 → 0.
- Load with ld_h_d = 2, ld_h_u = 4:
  - Required: state unchanged and load_err high for exactly 1 cycle.
  - Repeat with ld_m_d = 6: same response.
- mode_12h = 1 with loaded hours 00, 12, 13, 23:
  - Required display: 12/pm 0, 12/pm 1, 01/pm 1, 11/pm 1.
  - Internal count is unaffected by mode toggling.
- enable = 0 for 10 cycles mid-second:
  - Required: prescaler holds and no seg_tick.
  - On resume, the tick arrives after the remaining count only.
- clr and load asserted together: required result is 00:00:00 with no load_err. Async rst asserted between edges: outputs are 0 before the next clk edge.

Source files
------------

// File: rtl/contador_hms_param_if.sv
// +--------------------------------------------------------------------+
// | contador_hms_param_if: control, load and display bundle of the      |
// | HH:MM:SS counter. Rev 1.0                                          |
// +--------------------------------------------------------------------+
`default_nettype none

interface contador_hms_param_if;
  logic       enable;
  logic       clr;
  logic       load;
  logic [3:0] ld_h_d;
  logic [3:0] ld_h_u;
  logic [3:0] ld_m_d;
  logic [3:0] ld_m_u;
  logic [3:0] ld_s_d;
  logic [3:0] ld_s_u;
  logic       mode_12h;

  logic [3:0] s_unidade;
  logic [3:0] s_dezena;
  logic [3:0] m_unidade;
  logic [3:0] m_dezena;
  logic [3:0] h_unidade;
  logic [3:0] h_dezena;
  logic       pm;
  logic       seg_tick;
  logic       dia_tick;
  logic       load_err;

  modport master (
    output enable, clr, load, ld_h_d, ld_h_u, ld_m_d, ld_m_u, ld_s_d, ld_s_u, mode_12h,
    input  s_unidade, s_dezena, m_unidade, m_dezena, h_unidade, h_dezena,
           pm, seg_tick, dia_tick, load_err
  );

  modport slave (
    input  enable, clr, load, ld_h_d, ld_h_u, ld_m_d, ld_m_u, ld_s_d, ld_s_u, mode_12h,
    output s_unidade, s_dezena, m_unidade, m_dezena, h_unidade, h_dezena,
           pm, seg_tick, dia_tick, load_err
  );
endinterface

`default_nettype wire

// File: rtl/contador_hms_param.sv
// +--------------------------------------------------------------------+
// | contador_hms_param: BCD time-of-day counter with prescaler, 12/24 h |
// | display, validated load and registered tick pulses. Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module contador_hms_param #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  contador_hms_param_if.slave   bus
);

  localparam int             PW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  C_PRESC_MAX = PW'(CLK_HZ - 1);

  logic [3:0]    hd_q, hu_q, md_q, mu_q, sd_q, su_q;
  logic [3:0]    hd_d, hu_d, md_d, mu_d, sd_d, su_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          seg_tick_q, seg_tick_d;
  logic          dia_tick_q, dia_tick_d;
  logic          load_err_q, load_err_d;
  logic          ld_valid;

  assign ld_valid = (bus.ld_h_d <= 4'd2)
                 && ((bus.ld_h_d == 4'd2) ? (bus.ld_h_u <= 4'd3) : (bus.ld_h_u <= 4'd9))
                 && (bus.ld_m_d <= 4'd5) && (bus.ld_m_u <= 4'd9)
                 && (bus.ld_s_d <= 4'd5) && (bus.ld_s_u <= 4'd9);

  always_comb begin
    hd_d       = hd_q;
    hu_d       = hu_q;
    md_d       = md_q;
    mu_d       = mu_q;
    sd_d       = sd_q;
    su_d       = su_q;
    presc_d    = presc_q;
    seg_tick_d = 1'b0;
    dia_tick_d = 1'b0;
    load_err_d = 1'b0;

    if (bus.clr) begin
      hd_d    = 4'd0;
      hu_d    = 4'd0;
      md_d    = 4'd0;
      mu_d    = 4'd0;
      sd_d    = 4'd0;
      su_d    = 4'd0;
      presc_d = '0;
    end else if (bus.load) begin
      // A rejected load freezes everything, prescaler included.
      if (ld_valid) begin
        hd_d    = bus.ld_h_d;
        hu_d    = bus.ld_h_u;
        md_d    = bus.ld_m_d;
        mu_d    = bus.ld_m_u;
        sd_d    = bus.ld_s_d;
        su_d    = bus.ld_s_u;
        presc_d = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.enable) begin
      if (presc_q != C_PRESC_MAX) begin
        presc_d = presc_q + 1'b1;
      end else begin
        presc_d    = '0;
        seg_tick_d = 1'b1;
        if (su_q != 4'd9) begin
          su_d = su_q + 4'd1;
        end else begin
          su_d = 4'd0;
          if (sd_q != 4'd5) begin
            sd_d = sd_q + 4'd1;
          end else begin
            sd_d = 4'd0;
            if (mu_q != 4'd9) begin
              mu_d = mu_q + 4'd1;
            end else begin
              mu_d = 4'd0;
              if (md_q != 4'd5) begin
                md_d = md_q + 4'd1;
              end else begin
                md_d = 4'd0;
                if (hd_q == 4'd2 && hu_q == 4'd3) begin
                  hd_d       = 4'd0;
                  hu_d       = 4'd0;
                  dia_tick_d = 1'b1;
                end else if (hu_q == 4'd9) begin
                  hu_d = 4'd0;
                  hd_d = hd_q + 4'd1;
                end else begin
                  hu_d = hu_q + 4'd1;
                end
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hd_q       <= 4'd0;
      hu_q       <= 4'd0;
      md_q       <= 4'd0;
      mu_q       <= 4'd0;
      sd_q       <= 4'd0;
      su_q       <= 4'd0;
      presc_q    <= '0;
      seg_tick_q <= 1'b0;
      dia_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      hd_q       <= hd_d;
      hu_q       <= hu_d;
      md_q       <= md_d;
      mu_q       <= mu_d;
      sd_q       <= sd_d;
      su_q       <= su_d;
      presc_q    <= presc_d;
      seg_tick_q <= seg_tick_d;
      dia_tick_q <= dia_tick_d;
      load_err_q <= load_err_d;
    end
  end

  // Display hour is purely combinational so a mode switch shows up immediately.
  logic [4:0] hour_bin;
  logic [4:0] hour_12;
  logic [3:0] disp_hd, disp_hu;

  assign hour_bin = (5'(hd_q) * 5'd10) + 5'(hu_q);
  assign hour_12  = hour_bin - 5'd12;

  always_comb begin
    disp_hd = hd_q;
    disp_hu = hu_q;
    if (bus.mode_12h) begin
      if (hour_bin == 5'd0) begin
        disp_hd = 4'd1;
        disp_hu = 4'd2;
      end else if (hour_bin > 5'd12) begin
        if (hour_12 >= 5'd10) begin
          disp_hd = 4'd1;
          disp_hu = 4'(hour_12 - 5'd10);
        end else begin
          disp_hd = 4'd0;
          disp_hu = hour_12[3:0];
        end
      end
    end
  end

  assign bus.s_unidade = su_q;
  assign bus.s_dezena  = sd_q;
  assign bus.m_unidade = mu_q;
  assign bus.m_dezena  = md_q;
  assign bus.h_unidade = disp_hu;
  assign bus.h_dezena  = disp_hd;
  assign bus.pm        = (hour_bin >= 5'd12);
  assign bus.seg_tick  = seg_tick_q;
  assign bus.dia_tick  = dia_tick_q;
  assign bus.load_err  = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_contador_hms_param.sv
// +--------------------------------------------------------------------+
// | tb_contador_hms_param: directed self-checking bench, CLK_HZ = 4.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_contador_hms_param;

  localparam int CLK_HZ = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  contador_hms_param_if bus ();

  contador_hms_param #(.CLK_HZ(CLK_HZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [23:0] t_now();
    return {bus.h_dezena, bus.h_unidade, bus.m_dezena, bus.m_unidade,
            bus.s_dezena, bus.s_unidade};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ld(input logic [23:0] v);
    {bus.ld_h_d, bus.ld_h_u, bus.ld_m_d, bus.ld_m_u, bus.ld_s_d, bus.ld_s_u} = v;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst          = 1'b1;
    bus.enable   = 1'b0;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.mode_12h = 1'b0;
    set_ld(24'h000000);

    // Reset state, before any clock edge
    #3;
    chk("rst_time", t_now(), 24'h000000);
    chk("rst_flags", {bus.pm, bus.seg_tick, bus.dia_tick, bus.load_err}, 24'h0);
    bus.mode_12h = 1'b1;
    #1;
    chk("rst_12h_hour", {bus.h_dezena, bus.h_unidade}, 24'h12);
    bus.mode_12h = 1'b0;

    step();
    rst        = 1'b0;
    bus.enable = 1'b1;

    // Free run: seg_tick on every 4th cycle
    for (int i = 1; i <= 40; i++) begin
      step();
      chk($sformatf("run_tick_%0d", i), 24'(bus.seg_tick), 24'((i % 4) == 0));
    end
    chk("run_40_sec", {bus.s_dezena, bus.s_unidade}, 24'h10);

    // Day wrap
    set_ld(24'h235958);
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("ld_time", t_now(), 24'h235958);
    chk("ld_pm", 24'(bus.pm), 24'h1);
    chk("ld_noerr_notick", {bus.load_err, bus.seg_tick}, 24'h0);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("wrap_seg_%0d", i), 24'(bus.seg_tick), 24'(i == 4 || i == 8));
      chk($sformatf("wrap_dia_%0d", i), 24'(bus.dia_tick), 24'(i == 8));
      if (i == 4) chk("wrap_235959", t_now(), 24'h235959);
    end
    chk("wrap_000000", t_now(), 24'h000000);
    chk("wrap_pm", 24'(bus.pm), 24'h0);

    // Invalid load, hour 24: prescaler frozen during the rejected cycle
    step();                                   // prescaler -> 1
    set_ld(24'h240000);
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("bad_h_err", 24'(bus.load_err), 24'h1);
    chk("bad_h_time", t_now(), 24'h000000);
    step();                                   // prescaler -> 2
    chk("bad_h_err_drop", {bus.load_err, bus.seg_tick}, 24'h0);
    step();                                   // prescaler -> 3
    chk("bad_h_notick", 24'(bus.seg_tick), 24'h0);
    step();
    chk("bad_h_tick", 24'(bus.seg_tick), 24'h1);
    chk("bad_h_after", t_now(), 24'h000001);

    // Invalid load, minutes tens 6
    set_ld(24'h126000);
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("bad_m_err", 24'(bus.load_err), 24'h1);
    chk("bad_m_time", t_now(), 24'h000001);
    step();
    chk("bad_m_err_drop", 24'(bus.load_err), 24'h0);
    chk("bad_m_time2", t_now(), 24'h000001);

    // 12 h display
    bus.enable   = 1'b0;
    bus.mode_12h = 1'b1;
    set_ld(24'h000000); bus.load = 1'b1; step();
    chk("h12_00", {bus.h_dezena, bus.h_unidade, 7'd0, bus.pm}, 24'h1200);
    set_ld(24'h120000); step();
    chk("h12_12", {bus.h_dezena, bus.h_unidade, 7'd0, bus.pm}, 24'h1201);
    set_ld(24'h130000); step();
    chk("h12_13", {bus.h_dezena, bus.h_unidade, 7'd0, bus.pm}, 24'h0101);
    set_ld(24'h230000); step();
    bus.load = 1'b0;
    chk("h12_23", {bus.h_dezena, bus.h_unidade, 7'd0, bus.pm}, 24'h1101);
    bus.mode_12h = 1'b0;
    #1;
    chk("h24_23", {bus.h_dezena, bus.h_unidade, 7'd0, bus.pm}, 24'h2301);
    step();
    bus.mode_12h = 1'b1;
    #1;
    chk("h12_23_again", t_now(), 24'h110000);
    bus.mode_12h = 1'b0;

    // Enable pause mid-second
    bus.enable = 1'b1;
    step();
    step();                                   // prescaler = 2
    bus.enable = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("pause_notick_%0d", i), 24'(bus.seg_tick), 24'h0);
    end
    chk("pause_time", t_now(), 24'h230000);
    bus.enable = 1'b1;
    step();
    chk("resume_notick", 24'(bus.seg_tick), 24'h0);
    step();
    chk("resume_tick", 24'(bus.seg_tick), 24'h1);
    chk("resume_time", t_now(), 24'h230001);

    // clr beats load
    set_ld(24'h123456);
    bus.load = 1'b1;
    bus.clr  = 1'b1;
    step();
    chk("clr_ld_time", t_now(), 24'h000000);
    chk("clr_ld_err", 24'(bus.load_err), 24'h0);
    set_ld(24'h990000);
    step();
    chk("clr_badld_err", 24'(bus.load_err), 24'h0);
    bus.clr = 1'b0;

    // Async reset between edges
    set_ld(24'h123456);
    step();
    bus.load = 1'b0;
    chk("pre_rst_time", t_now(), 24'h123456);
    step();                                   // prescaler advancing
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_time", t_now(), 24'h000000);
    chk("async_rst_pm", 24'(bus.pm), 24'h0);
    step();
    #2;
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("post_rst_tick_%0d", i), 24'(bus.seg_tick), 24'(i == 4));
    end
    chk("post_rst_time", t_now(), 24'h000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
